// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending marks for decode hazard detection.
// Writeback commits and bypasses data in the same cycle; r0 is hardwired to zero.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  reg_write_in_wb,
    input  logic [ADDR_WIDTH-1:0] rd_in_wb,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  hazard,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    // Issue and writeback are single-cycle strobes with no back-pressure: an
    // asserted enable is consumed at the next rising edge, and decode alone
    // decides whether to stall on hazard.
    logic wr_active, iss_active, same_idx;
    logic cnt_inc, cnt_dec;
    logic rs_hz, rt_hz;

    assign wr_active  = reg_write_in_wb && (rd_in_wb != '0);
    assign iss_active = issue_valid && (issue_rd != '0);
    assign same_idx   = (issue_rd == rd_in_wb);

    // A re-issue of the retiring register keeps the mark: the newer producer wins.
    assign cnt_inc = iss_active && !pending_q[issue_rd];
    assign cnt_dec = wr_active && pending_q[rd_in_wb] && !(iss_active && same_idx);

    always_comb begin
        pending_d = pending_q;
        if (wr_active) begin
            pending_d[rd_in_wb] = 1'b0;
        end
        if (iss_active) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            if (wr_active) begin
                regs_q[rd_in_wb] <= wb_data_in;
            end
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wr_active && (rd_in_wb == rs_addr)) begin
            rs_data = wb_data_in;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wr_active && (rd_in_wb == rt_addr)) begin
            rt_data = wb_data_in;
        end
    end

    // A producer retiring this cycle no longer blocks its consumer.
    assign rs_hz = (rs_addr != '0) && pending_q[rs_addr]
                   && !(reg_write_in_wb && (rd_in_wb == rs_addr));
    assign rt_hz = (rt_addr != '0) && pending_q[rt_addr]
                   && !(reg_write_in_wb && (rd_in_wb == rt_addr));

    assign hazard        = rs_hz || rt_hz;
    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard plus fill/drain and reset sequences.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, rd_in_wb, issue_rd;
    logic [31:0] rs_data, rt_data, wb_data_in;
    logic        reg_write_in_wb, issue_valid, hazard;
    logic [5:0]  pending_count;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .reg_write_in_wb(reg_write_in_wb),
        .rd_in_wb       (rd_in_wb),
        .wb_data_in     (wb_data_in),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .hazard         (hazard),
        .pending_count  (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic        chk;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_hz;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Expected values describe outputs during the cycle, before the closing edge.
    task automatic add(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird, input logic chk,
                       input logic [31:0] e_rs, input logic [31:0] e_rt,
                       input logic e_hz, input logic [5:0] e_cnt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.we = we; v.rd = rd; v.wd = wd;
        v.iv = iv; v.ird = ird; v.chk = chk;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_hz = e_hz; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ird);
        @(negedge clk);
        reset = rst; rs_addr = rs; rt_addr = rt;
        reg_write_in_wb = we; rd_in_wb = rd; wb_data_in = wd;
        issue_valid = iv; issue_rd = ird;
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_rs, input logic [31:0] e_rt,
                             input logic e_hz, input logic [5:0] e_cnt);
        check({tag, " rs_data"}, rs_data, e_rs);
        check({tag, " rt_data"}, rt_data, e_rt);
        check({tag, " hazard"}, {31'b0, hazard}, {31'b0, e_hz});
        check({tag, " count"}, {26'b0, pending_count}, {26'b0, e_cnt});
    endtask

    initial begin
        reset = 1'b1; rs_addr = '0; rt_addr = '0;
        reg_write_in_wb = 1'b0; rd_in_wb = '0; wb_data_in = '0;
        issue_valid = 1'b0; issue_rd = '0;

        // Reset cycle with issue and writeback asserted: both must be ignored.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            check_all($sformatf("rst_read[%0d]", i), 32'h0, 32'h0, 1'b0, 6'd0);
        end

        //   rst  rs  rt  we  rd  wd            iv  ird chk e_rs          e_rt          hz  cnt
        add(1'b0, 5,  0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        add(1'b0, 5,  5, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        add(1'b0, 0,  5, 1'b1, 0, 32'h12345678, 1'b1, 0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        add(1'b0, 0,  0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 7,  0, 1'b0, 0, 32'h0,        1'b1, 7, 1'b1, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 7,  0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1, 1);
        add(1'b0, 7,  0, 1'b1, 7, 32'h42,       1'b0, 0, 1'b1, 32'h42,       32'h0,        1'b0, 1);
        add(1'b0, 7,  0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h42,       32'h0,        1'b0, 0);
        add(1'b0, 0,  9, 1'b0, 0, 32'h0,        1'b1, 9, 1'b1, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 0,  9, 1'b1, 9, 32'h99,       1'b1, 9, 1'b1, 32'h0,        32'h99,       1'b0, 1);
        add(1'b0, 0,  9, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h99,       1'b1, 1);
        add(1'b0, 4,  0, 1'b0, 0, 32'h0,        1'b1, 4, 1'b1, 32'h0,        32'h0,        1'b0, 1);
        add(1'b0, 4,  9, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h99,       1'b1, 2);
        add(1'b0, 4,  3, 1'b1, 4, 32'h44,       1'b1, 3, 1'b1, 32'h44,       32'h0,        1'b0, 2);
        add(1'b0, 4,  0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h44,       32'h0,        1'b0, 2);
        add(1'b0, 3,  0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1, 2);
        add(1'b0, 9,  0, 1'b1, 9, 32'h99,       1'b0, 0, 1'b1, 32'h99,       32'h0,        1'b0, 2);
        add(1'b0, 3,  9, 1'b1, 3, 32'h33,       1'b0, 0, 1'b1, 32'h33,       32'h99,       1'b0, 1);
        add(1'b0, 3,  9, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h33,       32'h99,       1'b0, 0);
        // Writeback to a non-pending register, and a repeated issue.
        add(1'b0, 10, 0, 1'b1, 10, 32'hA5,      1'b0, 0, 1'b1, 32'hA5,       32'h0,        1'b0, 0);
        add(1'b0, 10, 10, 1'b0, 0, 32'h0,       1'b0, 0, 1'b1, 32'hA5,       32'hA5,       1'b0, 0);
        add(1'b0, 0,  0, 1'b0, 0, 32'h0,        1'b1, 11, 1'b1, 32'h0,       32'h0,        1'b0, 0);
        add(1'b0, 11, 0, 1'b0, 0, 32'h0,        1'b1, 11, 1'b1, 32'h0,       32'h0,        1'b1, 1);
        add(1'b0, 11, 0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1, 1);
        add(1'b0, 11, 0, 1'b1, 11, 32'h11,      1'b0, 0, 1'b1, 32'h11,       32'h0,        1'b0, 1);
        add(1'b0, 11, 0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h11,       32'h0,        1'b0, 0);
        // Issue and writeback of the same non-pending register: the mark is set.
        add(1'b0, 12, 0, 1'b1, 12, 32'hC,       1'b1, 12, 1'b1, 32'hC,       32'h0,        1'b0, 0);
        add(1'b0, 12, 0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'hC,        32'h0,        1'b1, 1);
        add(1'b0, 12, 0, 1'b1, 12, 32'hCC,      1'b0, 0, 1'b1, 32'hCC,       32'h0,        1'b0, 1);
        add(1'b0, 12, 0, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'hCC,       32'h0,        1'b0, 0);
        // Reset mid-operation.
        add(1'b0, 0,  0, 1'b0, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 0,  0, 1'b0, 0, 32'h0,        1'b1, 2, 1'b0, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 0,  0, 1'b0, 0, 32'h0,        1'b1, 3, 1'b0, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 1,  2, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1, 3);
        add(1'b1, 1,  2, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1, 3);
        add(1'b0, 5,  10, 1'b0, 0, 32'h0,       1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b0, 0);
        add(1'b0, 2,  12, 1'b1, 2, 32'h5,       1'b0, 0, 1'b1, 32'h5,        32'h0,        1'b0, 0);
        add(1'b0, 2,  1, 1'b0, 0, 32'h0,        1'b0, 0, 1'b1, 32'h5,        32'h0,        1'b0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].we, vecs[i].rd,
                  vecs[i].wd, vecs[i].iv, vecs[i].ird);
            if (vecs[i].chk) begin
                check_all($sformatf("vec[%0d]", i), vecs[i].e_rs, vecs[i].e_rt,
                          vecs[i].e_hz, vecs[i].e_cnt);
            end
        end

        // Fill every nonzero register's mark, then drain them one by one.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
            check($sformatf("fill_count[%0d]", i), {26'b0, pending_count}, 32'(i - 1));
        end
        drive(1'b0, 5'd31, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check_all("full", 32'h0, 32'h0, 1'b1, 6'd31);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'd0, 1'b1, 5'(i), 32'(i * 3), 1'b0, 5'd0);
            check($sformatf("drain_count[%0d]", i), {26'b0, pending_count}, 32'(32 - i));
            check($sformatf("drain_hz[%0d]", i), {31'b0, hazard}, 32'h0);
            check($sformatf("drain_rs[%0d]", i), rs_data, 32'(i * 3));
        end
        drive(1'b0, 5'd31, 5'd17, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check_all("drained", 32'd93, 32'd51, 1'b0, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file and hazard scoreboard for the five-stage pipeline. The decode stage reads two source registers here. It also marks destination registers as pending when it issues an instruction. The writeback stage presents the retiring destination, write enable and data. This block commits the write, clears the pending mark, and bypasses the written value to same-cycle readers. Decode stalls on the `hazard` output.

## Interface
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 5: register index width; the file holds 2^ADDR_WIDTH registers.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rs_addr`  in  ADDR_WIDTH  read port A index.
- `rt_addr`  in  ADDR_WIDTH  read port B index.
- `rs_data`  out  DATA_WIDTH  read port A data (combinational).
- `rt_data`  out  DATA_WIDTH  read port B data (combinational).
- `reg_write_in_wb`  in  1  writeback commit enable.
- `rd_in_wb`  in  ADDR_WIDTH  writeback destination index.
- `wb_data_in`  in  DATA_WIDTH  writeback data.
- `issue_valid`  in  1  decode is issuing a register-writing instruction this cycle.
- `issue_rd`  in  ADDR_WIDTH  destination of the issuing instruction.
- `hazard`  out  1  rs or rt has an outstanding producer.
- `pending_count`  out  ADDR_WIDTH+1  number of registers currently marked pending.

## Operation
- State:
  - `regs[0..2^ADDR_WIDTH-1]`: DATA_WIDTH each.
  - `pending[0..2^ADDR_WIDTH-1]`: 1 bit each.
  - `pending_count` register.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked pending; issue with `issue_rd`=0 is a no-op.
- Write:
  - If `reg_write_in_wb` and `rd_in_wb`≠0: `regs[rd_in_wb]` ← `wb_data_in` at the edge.
  - `pending[rd_in_wb]` is cleared unless the same register is issued in the same cycle.
- Issue:
  - If `issue_valid` and `issue_rd`≠0: `pending[issue_rd]` ← 1.
  - Issue has priority over a same-cycle clear of the same index, because the newer producer wins.
- Read bypass:
  - If a write to a nonzero index is active and equals the read index, the read port returns `wb_data_in` in that cycle.
  - Otherwise it returns `regs[addr]`.
- Hazard: `hazard` = (`pending[rs_addr]` and not cleared-this-cycle) or (`pending[rt_addr]` and not cleared-this-cycle).
  - Cleared-this-cycle means `reg_write_in_wb` is high and `rd_in_wb` equals the index.
  - Index 0 never raises a hazard.
- Counter update per edge:
  - +1 when an issue sets a bit that was 0.
  - −1 when a writeback clears a bit that was 1 and that bit is not re-issued.
  - Both events in one cycle on different registers give net 0.
  - An issue to an already-pending register gives no change.
  - A writeback to a non-pending register gives no change and still writes the data.
- Issuing while `hazard` is high is legal; the bit is set regardless. Stall control belongs to decode.

## Timing
- Reset: at the first rising edge with `reset`=1:
  - all `regs` ← 0, all `pending` ← 0, `pending_count` ← 0.
  - `issue_valid` and writeback are ignored in that cycle.
- Reset mid-operation discards all pending marks. In-flight writebacks arriving after reset deasserts write normally and do not underflow the counter.
- Reads and `hazard` are combinational, with zero-cycle latency from address and writeback inputs.
- A write is visible via bypass in the same cycle. It is visible from `regs` from the next cycle on.
- `pending` and `pending_count` changes are visible the cycle after the edge.
- `pending_count` saturates neither up nor down. Its range is 0..2^ADDR_WIDTH−1 by construction.

## Test plan
- Reset, then read all indices:
  - `rs_data`=`rt_data`=0, `hazard`=0, `pending_count`=0.
- Bypass:
  - Write r5=0xDEADBEEF with `rs_addr`=5 in the same cycle → `rs_data`=0xDEADBEEF in that cycle.
  - The next cycle with no write → still 0xDEADBEEF.
- r0 protection:
  - Write r0=0x12345678 and issue rd=0 → `rs_data`(r0)=0, `hazard`=0, `pending_count`=0.
- Scoreboard:
  - Issue r7, then next cycle `rs_addr`=7 → `hazard`=1, `pending_count`=1.
  - Writeback r7=0x42 with `rs_addr`=7 in the same cycle → `hazard`=0, `rs_data`=0x42.
  - After the edge → `pending_count`=0.
- Simultaneous events:
  - Issue r9 and writeback r9 in the same cycle while r9 is pending → r9 stays pending, count unchanged.
  - Issue r3 and writeback pending r4 in the same cycle → count unchanged, `pending[4]`=0, `pending[3]`=1.
- Reset mid-operation:
  - Issue r1, r2, r3 (count=3), then assert `reset` for 1 cycle → count=0, all regs 0.
  - Then writeback r2=0x5 → r2 reads 0x5, count stays 0.
